// File: rtl/async_fifo_wrapper_pkg.sv
// Shared helpers for the single-clock token FIFO.
// Pointer comparisons are written once here so the flag logic reads cleanly.
// Pointers are passed zero-extended to 32 bits; aw is the index width.
package async_fifo_wrapper_pkg;

  // Queue is empty when both pointers, wrap flag included, match.
  function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp);
    return (wp == rp);
  endfunction

  // Queue is full when index bits match but the wrap flags differ.
  function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                    input int aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return ((wp & mask) == (rp & mask)) && (wp[aw] != rp[aw]);
  endfunction

endpackage

// File: rtl/async_fifo_wrapper_dpram.sv
// Simple dual-port array: synchronous write port, synchronous read port.
// Latency: read data appears one clk_i cycle after re_i; holds otherwise.
// No backpressure; the caller only enables accepted operations.
module fifo_dpram
  import async_fifo_wrapper_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage write; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; output clears on reset and holds when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/async_fifo_wrapper.sv
// Single-clock 2**ADDR_WIDTH-entry FIFO carrying DMA read-credit tokens.
// Latency: read data registered, valid one cycle after an accepted read.
// Writes while full are dropped and reads while empty ignored; flags registered.
module async_fifo_wrapper
  import async_fifo_wrapper_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  asyn_reset_i,
  input  logic                  w_en_i,
  input  logic [DATA_WIDTH-1:0] w_din_i,
  input  logic                  r_en_i,
  output logic [DATA_WIDTH-1:0] r_dout_o,
  output logic                  w_full_o,
  output logic                  r_empty_o
);

  // Extra MSB on each pointer is the wrap flag separating full from empty.
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_w_ptr;
  logic [PW-1:0] r_r_ptr;
  logic          r_full;
  logic          r_empty;

  logic          w_w_acc;
  logic          w_r_acc;
  logic [PW-1:0] w_w_ptr_nxt;
  logic [PW-1:0] w_r_ptr_nxt;

  // Accepts use only registered flags, so w_en_i/r_en_i never reach the flags combinationally.
  assign w_w_acc     = w_en_i & ~r_full;
  assign w_r_acc     = r_en_i & ~r_empty;
  assign w_w_ptr_nxt = r_w_ptr + PW'(w_w_acc);
  assign w_r_ptr_nxt = r_r_ptr + PW'(w_r_acc);

  // Pointer advance and flag update from post-operation pointers.
  // asyn_reset_i is expected to deassert synchronously to clk_i upstream.
  always_ff @(posedge clk_i or posedge asyn_reset_i) begin
    if (asyn_reset_i) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_w_ptr <= w_w_ptr_nxt;
      r_r_ptr <= w_r_ptr_nxt;
      r_empty <= ptr_empty(32'(w_w_ptr_nxt), 32'(w_r_ptr_nxt));
      r_full  <= ptr_full(32'(w_w_ptr_nxt), 32'(w_r_ptr_nxt), ADDR_WIDTH);
    end
  end

  fifo_dpram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (asyn_reset_i),
    .we_i   (w_w_acc),
    .waddr_i(r_w_ptr[ADDR_WIDTH-1:0]),
    .wdata_i(w_din_i),
    .re_i   (w_r_acc),
    .raddr_i(r_r_ptr[ADDR_WIDTH-1:0]),
    .rdata_o(r_dout_o)
  );

  assign w_full_o  = r_full;
  assign r_empty_o = r_empty;

endmodule

// File: tb/tb_async_fifo_wrapper.sv
// Directed bench for the token FIFO: vector table for fill/drain,
// plus hand sequences checked against a small queue model.
module tb_async_fifo_wrapper;

  logic clk;
  logic rst;
  logic w_en;
  logic w_din;
  logic r_en;
  logic r_dout;
  logic w_full;
  logic r_empty;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic w;
    logic d;
    logic r;
    logic exp_dout;
    logic exp_full;
    logic exp_empty;
  } vec_t;

  vec_t vecs[$];

  // Reference queue for the hand-written sequences.
  logic q_model[$];
  logic m_dout;

  async_fifo_wrapper #(3, 1) dut (
    .clk_i       (clk),
    .asyn_reset_i(rst),
    .w_en_i      (w_en),
    .w_din_i     (w_din),
    .r_en_i      (r_en),
    .r_dout_o    (r_dout),
    .w_full_o    (w_full),
    .r_empty_o   (r_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample #1 after the edge.
  task automatic step(input logic w, input logic d, input logic r);
    w_en  = w;
    w_din = d;
    r_en  = r;
    @(posedge clk);
    #1;
    w_en  = 1'b0;
    w_din = 1'b0;
    r_en  = 1'b0;
  endtask

  // One cycle checked against the queue model.
  task automatic do_op(input string nm, input logic w, input logic d, input logic r);
    logic wa;
    logic ra;
    wa = w && (q_model.size() < 8);
    ra = r && (q_model.size() > 0);
    step(w, d, r);
    if (ra) m_dout = q_model.pop_front();
    if (wa) q_model.push_back(d);
    chk({nm, ".dout"},  r_dout,  m_dout);
    chk({nm, ".full"},  w_full,  q_model.size() == 8);
    chk({nm, ".empty"}, r_empty, q_model.size() == 0);
  endtask

  initial begin
    logic [7:0] fill_pat;
    rst   = 1'b0;
    w_en  = 1'b0;
    w_din = 1'b0;
    r_en  = 1'b0;
    fill_pat = 8'b0100_1101; // LSB first: 1,0,1,1,0,0,1,0

    // Fill: 8 writes, full only after the 8th.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, fill_pat[i], 1'b0, 1'b0, (i == 7), 1'b0});
    // 9th write dropped.
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    // Drain: data in write order, empty after the 8th read.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b0, 1'b0, 1'b1, fill_pat[i], 1'b0, (i == 7)});
    // 9th read ignored, dout holds 0.
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    // Empty with write+read: only the write lands, no fall-through.
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});

    // Reset asserted between edges must act immediately.
    #2;
    rst = 1'b1;
    #1;
    chk("reset.empty", r_empty, 1'b1);
    chk("reset.full",  w_full,  1'b0);
    chk("reset.dout",  r_dout,  1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].d, vecs[i].r);
      chk($sformatf("vec%0d.dout", i),  r_dout,  vecs[i].exp_dout);
      chk($sformatf("vec%0d.full", i),  w_full,  vecs[i].exp_full);
      chk($sformatf("vec%0d.empty", i), r_empty, vecs[i].exp_empty);
    end

    // Model picks up from the table's end state: empty, dout = 1.
    q_model.delete();
    m_dout = 1'b1;

    // Concurrency at occupancy 4: flags steady, order preserved, pointers wrap.
    do_op("pre0", 1'b1, 1'b1, 1'b0);
    do_op("pre1", 1'b1, 1'b1, 1'b0);
    do_op("pre2", 1'b1, 1'b0, 1'b0);
    do_op("pre3", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      do_op($sformatf("conc%0d", i), 1'b1, iv[0] ^ iv[2], 1'b1);
    end

    // Top up to full, then write+read together: read wins, write dropped.
    for (int i = 0; i < 4; i++)
      do_op($sformatf("top%0d", i), 1'b1, 1'(i), 1'b0);
    chk("top.full_set", w_full, 1'b1);
    do_op("full_wr", 1'b1, 1'b0, 1'b1);
    chk("full_wr.full_clr", w_full, 1'b0);
    for (int i = 0; i < 8; i++)
      do_op($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b1);

    // Mid-operation reset at occupancy 5.
    for (int i = 0; i < 5; i++)
      do_op($sformatf("mr%0d", i), 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.empty", r_empty, 1'b1);
    chk("midrst.full",  w_full,  1'b0);
    chk("midrst.dout",  r_dout,  1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_model.delete();
    m_dout = 1'b0;
    do_op("post_wr", 1'b1, 1'b1, 1'b0);
    do_op("post_rd", 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
